// File: rtl/dp_sched.sv
// dp_sched: shares the single s/y datapath between requesters A and B.
// Round-robin arbitration in IDLE, then runs the ENUM / COUNT / UPD control
// sequence on the datapath control points and pulses done on completion.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   a_valid/a_op, b_valid/b_op  requester op requests (0 NOP,1 ENUM,2 COUNT,3 UPD)
//   a_ready, b_ready         accept strobe (valid & ready = transfer)
//   start                    COUNT continue qualifier
//   s                        current datapath s value
//   s_en/s_zero/s_sub/s_step s register control
//   y_en/y_upd/y_select_next y register control
//   busy/owner/regime/active status; done one-cycle completion pulse
module dp_sched #(
  parameter int unsigned ENUM_DWELL = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       a_valid,
  input  logic [1:0] a_op,
  input  logic       b_valid,
  input  logic [1:0] b_op,
  output logic       a_ready,
  output logic       b_ready,
  input  logic       start,
  input  logic [2:0] s,
  output logic       s_en,
  output logic       s_zero,
  output logic       s_sub,
  output logic [1:0] s_step,
  output logic       y_en,
  output logic       y_upd,
  output logic [1:0] y_select_next,
  output logic       busy,
  output logic       owner,
  output logic [1:0] regime,
  output logic       active,
  output logic       done
);

  typedef enum logic [2:0] {
    IDLE, E_CLR, E_STEP, E_WAIT, C_RUN, U_LOAD, U_UPD
  } state_t;

  localparam logic [2:0] DWELL_LAST = 3'(ENUM_DWELL - 1);

  state_t     state_q, state_d;
  logic       ptr_q, ptr_d;
  logic       owner_q, owner_d;
  logic       done_q, done_d;
  logic [1:0] rnd_q, rnd_d;
  logic [2:0] dwell_q, dwell_d;
  logic       grant_a, grant_b;
  logic [1:0] win_op;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      owner_q <= 1'b0;
      done_q  <= 1'b0;
      rnd_q   <= '0;
      dwell_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      done_q  <= done_d;
      rnd_q   <= rnd_d;
      dwell_q <= dwell_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    owner_d       = owner_q;
    done_d        = 1'b0;
    rnd_d         = rnd_q;
    dwell_d       = dwell_q;
    grant_a       = 1'b0;
    grant_b       = 1'b0;
    win_op        = '0;
    s_en          = 1'b0;
    s_zero        = 1'b0;
    s_sub         = 1'b0;
    s_step        = '0;
    y_en          = 1'b0;
    y_upd         = 1'b0;
    y_select_next = '0;
    case (state_q)
      IDLE: begin
        // ptr only matters when both sides are valid
        grant_a = a_valid && (!b_valid || !ptr_q);
        grant_b = b_valid && (!a_valid || ptr_q);
        win_op  = grant_b ? b_op : a_op;
        if (grant_a || grant_b) begin
          owner_d = grant_b;
          ptr_d   = !grant_b;
          case (win_op)
            2'd0:    done_d  = 1'b1;
            2'd1:    state_d = E_CLR;
            2'd2:    state_d = C_RUN;
            default: state_d = U_LOAD;
          endcase
        end
      end
      E_CLR: begin
        s_en    = 1'b1;
        s_zero  = 1'b1;
        rnd_d   = '0;
        state_d = E_STEP;
      end
      E_STEP: begin
        s_en    = 1'b1;
        s_sub   = 1'b1;
        s_step  = 2'd2;
        dwell_d = DWELL_LAST;
        state_d = E_WAIT;
      end
      E_WAIT: begin
        if (dwell_q == '0) begin
          if (rnd_q == 2'd3) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            rnd_d   = rnd_q + 2'd1;
            state_d = E_STEP;
          end
        end else begin
          dwell_d = dwell_q - 3'd1;
        end
      end
      C_RUN: begin
        if (start) begin
          s_en   = 1'b1;
          s_sub  = 1'b1;
          s_step = 2'd1;
          if (s == '0) begin
            y_en          = 1'b1;
            y_select_next = 2'd2;
          end
        end else begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      U_LOAD: begin
        y_en          = 1'b1;
        y_select_next = 2'd0;
        state_d       = U_UPD;
      end
      U_UPD: begin
        y_en          = 1'b1;
        y_upd         = 1'b1;
        y_select_next = 2'd1;
        s_en          = 1'b1;
        s_sub         = 1'b1;
        s_step        = 2'd1;
        state_d       = IDLE;
        done_d        = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // ready is combinational from valid, so mask it while reset is held
  assign a_ready = grant_a && !rst;
  assign b_ready = grant_b && !rst;

  always_comb begin
    regime = '0;
    case (state_q)
      E_CLR, E_STEP, E_WAIT: regime = 2'd1;
      C_RUN:                 regime = 2'd2;
      U_LOAD, U_UPD:         regime = 2'd3;
      default:               regime = '0;
    endcase
  end

  assign active = (state_q == E_STEP) || (state_q == E_WAIT);
  assign busy   = (state_q != IDLE);
  assign owner  = owner_q;
  assign done   = done_q;

endmodule
